// File: rtl/sys_arr_db.sv
// sys_arr_db: ROWS x COLS weight-stationary systolic MAC array
// with double-buffered weights and a drain-safe shadow swap.
module sys_arr_db #(
  parameter int ROWS = 4,
  parameter int COLS = 4,
  parameter int DW   = 8,
  parameter int AW   = 32
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [ROWS*DW-1:0] datain,
  input  logic [ROWS-1:0]    datain_valid,
  output logic               din_ready,
  input  logic [COLS*AW-1:0] sumin,
  input  logic               sign_mode,
  input  logic [COLS*DW-1:0] win,
  input  logic               wload,
  input  logic               wswap,
  output logic               wfull,
  output logic [COLS*AW-1:0] maccout,
  output logic [COLS-1:0]    maccout_valid,
  output logic [ROWS*DW-1:0] dataout,
  output logic [ROWS-1:0]    dataout_valid
);

  localparam int KW = $clog2(ROWS + 1);

  typedef enum logic [1:0] {
    S_EMPTY,
    S_LOADING,
    S_FULL,
    S_PENDING
  } st_t;

  st_t           r_st;
  st_t           w_st_nx;
  logic [KW-1:0] r_cnt;
  logic          w_shift;
  logic          w_swap;
  logic          w_busy;

  logic [DW-1:0] r_wact [ROWS][COLS];
  logic [DW-1:0] r_wsh  [ROWS][COLS];

  logic [DW-1:0] r_data [ROWS][COLS];
  logic          r_vld  [ROWS][COLS];
  logic [AW-1:0] r_sum  [ROWS][COLS];

  logic [DW-1:0] w_a    [ROWS][COLS];
  logic          w_v    [ROWS][COLS];
  logic [AW-1:0] w_s    [ROWS][COLS];
  logic [AW-1:0] w_pe   [ROWS][COLS];

  always_comb begin
    w_busy = 1'b0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        w_busy = w_busy | r_vld[r][c];
      end
    end
  end

  always_comb begin
    w_st_nx   = r_st;
    w_shift   = 1'b0;
    w_swap    = 1'b0;
    wfull     = 1'b0;
    din_ready = 1'b1;
    unique case (r_st)
      S_EMPTY: begin
        if (wload) begin
          w_shift = 1'b1;
          if (ROWS == 1) w_st_nx = S_FULL;
          else           w_st_nx = S_LOADING;
        end
      end
      S_LOADING: begin
        if (wload) begin
          w_shift = 1'b1;
          if (r_cnt == KW'(ROWS - 1)) w_st_nx = S_FULL;
        end
      end
      S_FULL: begin
        wfull = 1'b1;
        if (wswap) w_st_nx = S_PENDING;
      end
      S_PENDING: begin
        wfull     = 1'b1;
        din_ready = 1'b0;
        // Promote only once every in-flight MAC has left the array
        if (!w_busy) begin
          w_swap  = 1'b1;
          w_st_nx = S_EMPTY;
        end
      end
      default: w_st_nx = S_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_st  <= S_EMPTY;
      r_cnt <= '0;
    end else begin
      r_st <= w_st_nx;
      if (w_swap)       r_cnt <= '0;
      else if (w_shift) r_cnt <= r_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int r = 0; r < ROWS; r++) begin
        for (int c = 0; c < COLS; c++) begin
          r_wsh[r][c]  <= '0;
          r_wact[r][c] <= '0;
        end
      end
    end else begin
      for (int c = 0; c < COLS; c++) begin
        if (w_shift) begin
          r_wsh[0][c] <= win[c*DW +: DW];
          for (int r = 1; r < ROWS; r++) begin
            r_wsh[r][c] <= r_wsh[r-1][c];
          end
        end
        if (w_swap) begin
          for (int r = 0; r < ROWS; r++) begin
            r_wact[r][c] <= r_wsh[r][c];
          end
        end
      end
    end
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      logic signed [DW:0]     w_ax;
      logic signed [DW:0]     w_wx;
      logic signed [2*DW+1:0] w_p;

      if (c == 0) begin : g_edge
        assign w_v[r][c] = datain_valid[r] & din_ready;
        assign w_a[r][c] = w_v[r][c] ? datain[r*DW +: DW] : '0;
      end else begin : g_pass
        assign w_v[r][c] = r_vld[r][c-1];
        assign w_a[r][c] = r_data[r][c-1];
      end

      if (r == 0) begin : g_top
        assign w_s[r][c] = sumin[c*AW +: AW];
      end else begin : g_acc
        assign w_s[r][c] = r_sum[r-1][c];
      end

      // One extra bit lets a single signed multiplier serve both modes
      assign w_ax = {sign_mode & w_a[r][c][DW-1], w_a[r][c]};
      assign w_wx = {sign_mode & r_wact[r][c][DW-1], r_wact[r][c]};
      assign w_p  = w_ax * w_wx;
      assign w_pe[r][c] = AW'(w_p);
    end
  end

  always_ff @(posedge clk) begin
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        if (!reset_n) begin
          r_data[r][c] <= '0;
          r_vld[r][c]  <= 1'b0;
          r_sum[r][c]  <= '0;
        end else begin
          r_data[r][c] <= w_a[r][c];
          r_vld[r][c]  <= w_v[r][c];
          r_sum[r][c]  <= w_v[r][c] ? w_s[r][c] + w_pe[r][c] : '0;
        end
      end
    end
  end

  for (genvar c = 0; c < COLS; c++) begin : g_bot
    assign maccout[c*AW +: AW] = r_sum[ROWS-1][c];
    assign maccout_valid[c]    = r_vld[ROWS-1][c];
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_right
    assign dataout[r*DW +: DW] = r_data[r][COLS-1];
    assign dataout_valid[r]    = r_vld[r][COLS-1];
  end

endmodule

// File: tb/tb_sys_arr_db.sv
// tb_sys_arr_db: directed vectors for a 2x2 sys_arr_db
// covering load/swap, MAC timing, sign modes and drain.
module tb_sys_arr_db;

  localparam int ROWS = 2;
  localparam int COLS = 2;
  localparam int DW   = 8;
  localparam int AW   = 32;

  logic               clk = 1'b0;
  logic               reset_n;
  logic [ROWS*DW-1:0] datain;
  logic [ROWS-1:0]    datain_valid;
  logic               din_ready;
  logic [COLS*AW-1:0] sumin;
  logic               sign_mode;
  logic [COLS*DW-1:0] win;
  logic               wload;
  logic               wswap;
  logic               wfull;
  logic [COLS*AW-1:0] maccout;
  logic [COLS-1:0]    maccout_valid;
  logic [ROWS*DW-1:0] dataout;
  logic [ROWS-1:0]    dataout_valid;

  int n_run  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  sys_arr_db #(
    .ROWS(ROWS), .COLS(COLS), .DW(DW), .AW(AW)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .datain       (datain),
    .datain_valid (datain_valid),
    .din_ready    (din_ready),
    .sumin        (sumin),
    .sign_mode    (sign_mode),
    .win          (win),
    .wload        (wload),
    .wswap        (wswap),
    .wfull        (wfull),
    .maccout      (maccout),
    .maccout_valid(maccout_valid),
    .dataout      (dataout),
    .dataout_valid(dataout_valid)
  );

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    datain       = '0;
    datain_valid = '0;
    sumin        = '0;
    win          = '0;
    wload        = 1'b0;
    wswap        = 1'b0;
  endtask

  task automatic load2(input logic [15:0] a,
                       input logic [15:0] b);
    win = a; wload = 1'b1;
    step; chk("ld1_full", 64'(wfull), 64'd0);
    win = b;
    step; chk("ld2_full", 64'(wfull), 64'd1);
    wload = 1'b0; win = '0; wswap = 1'b1;
    step;
    chk("pend_rdy", 64'(din_ready), 64'd0);
    chk("pend_full", 64'(wfull), 64'd1);
    wswap = 1'b0;
    step;
    chk("swp_full", 64'(wfull), 64'd0);
    chk("swp_rdy", 64'(din_ready), 64'd1);
  endtask

  // Skewed 2-row vector; col0 result one cycle before col1
  task automatic mac2(input string tag,
                      input logic [7:0] x0, input logic [7:0] x1,
                      input logic [31:0] s0, input logic [31:0] s1,
                      input logic [31:0] e0, input logic [31:0] e1);
    datain = {8'h00, x0}; datain_valid = 2'b01;
    sumin = {32'h0, s0};
    step;
    datain = {x1, 8'h00}; datain_valid = 2'b10;
    sumin = {s1, 32'h0};
    step;
    chk({tag, "_c0"}, 64'(maccout[31:0]), 64'(e0));
    chk({tag, "_v0"}, 64'(maccout_valid), 64'd1);
    chk({tag, "_d0"}, 64'(dataout[7:0]), 64'(x0));
    chk({tag, "_dv0"}, 64'(dataout_valid), 64'd1);
    idle;
    step;
    chk({tag, "_c1"}, 64'(maccout[63:32]), 64'(e1));
    chk({tag, "_v1"}, 64'(maccout_valid), 64'd2);
    chk({tag, "_d1"}, 64'(dataout[15:8]), 64'(x1));
    step;
    chk({tag, "_vend"}, 64'(maccout_valid), 64'd0);
  endtask

  initial begin
    idle;
    sign_mode = 1'b0;
    reset_n   = 1'b0;

    datain       = 16'($urandom);
    datain_valid = 2'($urandom);
    sumin        = {$urandom, $urandom};
    win          = 16'($urandom);
    wload        = 1'($urandom);
    wswap        = 1'($urandom);
    sign_mode    = 1'($urandom);
    step;
    step;
    chk("rst_macc", maccout, 64'd0);
    chk("rst_mv", 64'(maccout_valid), 64'd0);
    chk("rst_dout", 64'(dataout), 64'd0);
    chk("rst_dv", 64'(dataout_valid), 64'd0);
    chk("rst_rdy", 64'(din_ready), 64'd1);
    chk("rst_full", 64'(wfull), 64'd0);
    idle;
    sign_mode = 1'b0;
    reset_n   = 1'b1;
    step;
    mac2("w0", 8'd5, 8'd7, 32'd3, 32'd4, 32'd3, 32'd4);

    load2(16'h0102, 16'h0304);
    mac2("t3a", 8'd1, 8'd1, 32'd0, 32'd0, 32'd6, 32'd4);
    mac2("t3b", 8'd2, 8'd3, 32'd10, 32'd100, 32'd24, 32'd109);

    load2(16'h0000, 16'h01FF);
    sign_mode = 1'b1;
    mac2("t4s", 8'd2, 8'd0, 32'd0, 32'd0, 32'hFFFFFFFE, 32'd2);
    sign_mode = 1'b0;
    mac2("t4u", 8'd2, 8'd0, 32'd0, 32'd0, 32'd510, 32'd2);
    sign_mode = 1'b1;
    mac2("t4sn", 8'hFE, 8'd0, 32'd0, 32'd0, 32'd2, 32'hFFFFFFFE);
    sign_mode = 1'b0;
    mac2("t4un", 8'hFE, 8'd0, 32'd0, 32'd0, 32'd64770, 32'd254);
    mac2("wrap", 8'd1, 8'd0, 32'd0, 32'hFFFFFFFF, 32'd255, 32'd0);

    win = 16'h0201; wload = 1'b1;
    step; chk("b_ld1", 64'(wfull), 64'd0);
    wload = 1'b0; wswap = 1'b1;
    step;
    chk("b_swpld_full", 64'(wfull), 64'd0);
    chk("b_swpld_rdy", 64'(din_ready), 64'd1);
    wswap = 1'b0; win = 16'h0403; wload = 1'b1;
    step; chk("b_ld2", 64'(wfull), 64'd1);
    win = 16'h7F7F;
    step;
    chk("b_ldfull_full", 64'(wfull), 64'd1);
    chk("b_ldfull_rdy", 64'(din_ready), 64'd1);
    wswap = 1'b1;
    step; chk("b_both_rdy", 64'(din_ready), 64'd0);
    idle;
    step; chk("b_swp", 64'(wfull), 64'd0);
    mac2("b_w", 8'd1, 8'd1, 32'd0, 32'd0, 32'd4, 32'd6);

    win = 16'h0505; wload = 1'b1;
    step;
    win = 16'h0606;
    step;
    wload = 1'b0; win = '0;
    chk("s_full", 64'(wfull), 64'd1);
    datain = {8'h00, 8'd1}; datain_valid = 2'b01;
    step;
    datain = {8'd2, 8'd2}; datain_valid = 2'b11;
    step;
    chk("s_e1_c0", 64'(maccout[31:0]), 64'd5);
    chk("s_e1_v", 64'(maccout_valid), 64'd1);
    datain = {8'd1, 8'h00}; datain_valid = 2'b10; wswap = 1'b1;
    step;
    chk("s_e2_c0", 64'(maccout[31:0]), 64'd7);
    chk("s_e2_c1", 64'(maccout[63:32]), 64'd8);
    chk("s_e2_v", 64'(maccout_valid), 64'd3);
    chk("s_e2_rdy", 64'(din_ready), 64'd0);
    wswap = 1'b0; datain = 16'h0909; datain_valid = 2'b11;
    step;
    chk("s_e3_c1", 64'(maccout[63:32]), 64'd10);
    chk("s_e3_v", 64'(maccout_valid), 64'd2);
    chk("s_e3_rdy", 64'(din_ready), 64'd0);
    step;
    chk("s_e4_v", 64'(maccout_valid), 64'd0);
    chk("s_e4_dv", 64'(dataout_valid), 64'd0);
    chk("s_e4_rdy", 64'(din_ready), 64'd0);
    step;
    chk("s_e5_rdy", 64'(din_ready), 64'd1);
    chk("s_e5_full", 64'(wfull), 64'd0);
    idle;
    mac2("s_new", 8'd1, 8'd1, 32'd0, 32'd0, 32'd11, 32'd11);

    win = 16'h0707; wload = 1'b1;
    step;
    step;
    wload = 1'b0; wswap = 1'b1;
    step; chk("r_pend", 64'(din_ready), 64'd0);
    idle;
    reset_n = 1'b0;
    step;
    reset_n = 1'b1;
    chk("r_full", 64'(wfull), 64'd0);
    chk("r_rdy", 64'(din_ready), 64'd1);
    step;
    mac2("r_w0", 8'd1, 8'd1, 32'd5, 32'd6, 32'd5, 32'd6);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
